// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and RAM port of mem_arbiter.
// slave is the arbiter's view; master is the requester/RAM environment view.
// Handshake: a request is taken in the cycle its *_gnt is high; until then the
// requester holds *_req and all request fields stable. Responses carry no
// back-pressure: *_rvalid is a one-cycle strobe with the data alongside.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [31:0]       if_rdata;
   logic              d_req;
   logic              d_we;
   logic [1:0]        d_size;
   logic [ADDR_W-1:0] d_addr;
   logic [31:0]       d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [31:0]       d_rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;
   logic              busy;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, ram_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
      output ram_addr, ram_we, ram_wdata, busy
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, ram_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
      input  ram_addr, ram_we, ram_wdata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of a fixed-latency single-port word RAM
// between instruction fetch and load/store, with a tag pipeline that routes
// read data back to its requester. With MEM_ARB_RMW_EN defined, byte/half
// stores become read-modify-write sequences; otherwise every store writes the
// full d_wdata word.
module mem_arbiter #(
   parameter int RAM_LATENCY = 2,
   parameter int ADDR_W      = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.slave  bus,
   output logic [1:0]    dbg_state_o
);

   localparam int LAST = RAM_LATENCY - 1;
   localparam int CW   = (RAM_LATENCY > 2) ? $clog2(RAM_LATENCY) : 1;

`ifdef MEM_ARB_RMW_EN
   typedef enum logic [1:0] {IDLE = 2'd0, RMW_WAIT = 2'd1, RMW_WRITE = 2'd2} state_e;
   typedef enum logic [1:0] {DST_IF = 2'd0, DST_D = 2'd1, DST_INT = 2'd2} dest_e;
`else
   typedef enum logic [1:0] {IDLE = 2'd0} state_e;
   typedef enum logic [1:0] {DST_IF = 2'd0, DST_D = 2'd1} dest_e;
`endif

   state_e                 state_q, state_d;
   logic                   last_d_q, last_d_d;   // 1: data port had the latest grant
   logic [RAM_LATENCY-1:0] tv_q;                 // tag valid per stage
   dest_e                  td_q [RAM_LATENCY];   // tag destination per stage
   logic                   push_v;
   dest_e                  push_dst;
   logic                   if_win, d_win;

`ifdef MEM_ARB_RMW_EN
   logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
   logic [15:0]       rmw_data_q, rmw_data_d;
   logic              rmw_half_q, rmw_half_d;
   logic [CW-1:0]     wait_q, wait_d;
   logic [31:0]       merged;
`else
   logic unused_size;
   assign unused_size = ^bus.d_size;
`endif

   // Arbitration, RAM command and FSM next state.
   always_comb begin
      state_d       = state_q;
      last_d_d      = last_d_q;
      if_win        = 1'b0;
      d_win         = 1'b0;
      push_v        = 1'b0;
      push_dst      = DST_IF;
      bus.ram_addr  = '0;
      bus.ram_we    = 1'b0;
      bus.ram_wdata = '0;
`ifdef MEM_ARB_RMW_EN
      rmw_addr_d    = rmw_addr_q;
      rmw_data_d    = rmw_data_q;
      rmw_half_d    = rmw_half_q;
      wait_d        = wait_q;
`endif
      case (state_q)
         IDLE: begin
            // Fetch wins unless data also requests and fetch went last.
            if_win = bus.if_req && (!bus.d_req || last_d_q);
            d_win  = bus.d_req && !if_win;
            if (if_win) begin
               bus.ram_addr = bus.if_addr;
               push_v       = 1'b1;
               push_dst     = DST_IF;
               last_d_d     = 1'b0;
            end else if (d_win) begin
               bus.ram_addr = bus.d_addr;
               last_d_d     = 1'b1;
               if (!bus.d_we) begin
                  push_v   = 1'b1;
                  push_dst = DST_D;
               end
`ifdef MEM_ARB_RMW_EN
               else if (!bus.d_size[1]) begin
                  // Sub-word store: read the word back internally first.
                  push_v     = 1'b1;
                  push_dst   = DST_INT;
                  rmw_addr_d = bus.d_addr;
                  rmw_data_d = bus.d_wdata[15:0];
                  rmw_half_d = bus.d_size[0];
                  wait_d     = CW'(RAM_LATENCY - 2);
                  state_d    = RMW_WAIT;
               end
`endif
               else begin
                  bus.ram_we    = 1'b1;
                  bus.ram_wdata = bus.d_wdata;
               end
            end
         end
`ifdef MEM_ARB_RMW_EN
         RMW_WAIT: begin
            if (wait_q == '0) state_d = RMW_WRITE;
            else              wait_d  = wait_q - 1'b1;
         end
         RMW_WRITE: begin
            bus.ram_addr  = rmw_addr_q;
            bus.ram_we    = 1'b1;
            bus.ram_wdata = merged;
            state_d       = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

`ifdef MEM_ARB_RMW_EN
   // Little-endian lane merge of the latched store data into the read word.
   always_comb begin
      merged = bus.ram_rdata;
      if (rmw_half_q) begin
         if (rmw_addr_q[1]) merged[31:16] = rmw_data_q;
         else               merged[15:0]  = rmw_data_q;
      end else begin
         case (rmw_addr_q[1:0])
            2'd0:    merged[7:0]   = rmw_data_q[7:0];
            2'd1:    merged[15:8]  = rmw_data_q[7:0];
            2'd2:    merged[23:16] = rmw_data_q[7:0];
            default: merged[31:24] = rmw_data_q[7:0];
         endcase
      end
   end

   // RMW context registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rmw_addr_q <= '0;
         rmw_data_q <= '0;
         rmw_half_q <= 1'b0;
         wait_q     <= '0;
      end else begin
         rmw_addr_q <= rmw_addr_d;
         rmw_data_q <= rmw_data_d;
         rmw_half_q <= rmw_half_d;
         wait_q     <= wait_d;
      end
   end
`endif

   // FSM state and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         last_d_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
      end
   end

   // Tag pipeline, one stage per RAM latency cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tv_q <= '0;
         for (int i = 0; i < RAM_LATENCY; i++) td_q[i] <= DST_IF;
      end else begin
         tv_q[0] <= push_v;
         td_q[0] <= push_dst;
         for (int i = 1; i < RAM_LATENCY; i++) begin
            tv_q[i] <= tv_q[i-1];
            td_q[i] <= td_q[i-1];
         end
      end
   end

   assign bus.if_gnt    = if_win;
   assign bus.d_gnt     = d_win;
   assign bus.if_rvalid = tv_q[LAST] && (td_q[LAST] == DST_IF);
   assign bus.d_rvalid  = tv_q[LAST] && (td_q[LAST] == DST_D);
   assign bus.if_rdata  = bus.if_rvalid ? bus.ram_rdata : '0;
   assign bus.d_rdata   = bus.d_rvalid  ? bus.ram_rdata : '0;
   assign bus.busy      = (state_q != IDLE);
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic for mem_arbiter,
// checked against a transaction-level model (shadow memory, grant rules,
// response schedule). Honours MEM_ARB_RMW_EN like the design.
module tb_mem_arbiter;
   localparam int ADDR_W = 32;
   localparam int LAT    = 2;
`ifdef MEM_ARB_RMW_EN
   localparam bit          RMW      = 1'b1;
   localparam logic [31:0] EXP_BYTE = 32'h1122AA44;
   localparam logic [31:0] EXP_HALF = 32'hBEEFAA44;
   localparam logic [31:0] EXP_WAIT = 32'd2;
   localparam logic [31:0] EXP_RST  = 32'h5A5A5A5A;
`else
   localparam bit          RMW      = 1'b0;
   localparam logic [31:0] EXP_BYTE = 32'h000000AA;
   localparam logic [31:0] EXP_HALF = 32'h0000BEEF;
   localparam logic [31:0] EXP_WAIT = 32'd0;
   localparam logic [31:0] EXP_RST  = 32'h00000077;
`endif

   // clock / reset
   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] dbg_state;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W)) ab ();
   mem_arbiter #(.RAM_LATENCY(LAT), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(ab.slave), .dbg_state_o(dbg_state)
   );

   // RAM: registered address in, registered data out; preload port for setup.
   logic [31:0] mem [0:511];
   logic [31:0] ram_a_q, ram_d_q;
   logic        pre_we;
   logic [8:0]  pre_a;
   logic [31:0] pre_d;
   always @(posedge clk) begin
      ram_a_q <= ab.ram_addr;
      ram_d_q <= mem[ram_a_q[10:2]];
      if (pre_we)         mem[pre_a] <= pre_d;
      else if (ab.ram_we) mem[ab.ram_addr[10:2]] <= ab.ram_wdata;
   end
   assign ab.ram_rdata = ram_d_q;

   // scoreboard / model state
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [31:0] ref_mem [0:511];
   logic        exp_if_v [0:7];
   logic [31:0] exp_if_d [0:7];
   logic        exp_d_v  [0:7];
   logic [31:0] exp_d_d  [0:7];
   int          m_busy;
   logic        m_last_d;
   logic [31:0] m_rmw_addr;
   logic        g_if, g_d, obs_d_gnt;
   logic [31:0] if_cap, d_cap;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'(a[10:2]);
   endfunction

   // Store result as the spec defines it: lane insert for byte/half, else whole word.
   function automatic logic [31:0] store_val(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [1:0] sz, input logic [31:0] a);
      int          sh;
      logic [31:0] m;
      if (!RMW || sz[1]) return wd;
      if (sz == 2'b00) begin sh = 8 * int'(a[1:0]); m = 32'h0000_00FF << sh; end
      else             begin sh = 16 * int'(a[1]);  m = 32'h0000_FFFF << sh; end
      return (old & ~m) | ((wd << sh) & m);
   endfunction

   task automatic clear_model();
      m_busy   = 0;
      m_last_d = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_if_v[i] = 1'b0; exp_d_v[i] = 1'b0;
      end
   endtask

   // One clock: check outputs at negedge against the model, advance the model,
   // then retire granted requests just after the next rising edge.
   task automatic cycle();
      logic e_ig, e_dg, e_we, e_busy;
      int   s, wi;
      @(negedge clk);
      s = cyc % 8;
      e_ig = 1'b0; e_dg = 1'b0;
      obs_d_gnt = ab.d_gnt;
      if (ab.if_rvalid) if_cap = ab.if_rdata;
      if (ab.d_rvalid)  d_cap  = ab.d_rdata;
      if (!rst_n) begin
         check("rst_if_gnt", ab.if_gnt, 0);
         check("rst_d_gnt", ab.d_gnt, 0);
         check("rst_busy", ab.busy, 0);
         check("rst_ram_we", ab.ram_we, 0);
         check("rst_ram_addr", ab.ram_addr, 0);
         check("rst_ram_wdata", ab.ram_wdata, 0);
         check("rst_if_rvalid", ab.if_rvalid, 0);
         check("rst_d_rvalid", ab.d_rvalid, 0);
         check("rst_if_rdata", ab.if_rdata, 0);
         check("rst_d_rdata", ab.d_rdata, 0);
      end else begin
         if (m_busy == 0) begin
            if (ab.if_req && (!ab.d_req || m_last_d)) e_ig = 1'b1;
            else if (ab.d_req)                        e_dg = 1'b1;
         end
         e_busy = (m_busy != 0);
         e_we   = (m_busy == 1) || (e_dg && ab.d_we && (!RMW || ab.d_size[1]));
         check("if_gnt", ab.if_gnt, e_ig);
         check("d_gnt", ab.d_gnt, e_dg);
         check("busy", ab.busy, e_busy);
         check("ram_we", ab.ram_we, e_we);
         if (e_ig) check("ram_addr_if", ab.ram_addr, ab.if_addr);
         if (e_dg) check("ram_addr_d", ab.ram_addr, ab.d_addr);
         if (e_dg && e_we) check("ram_wdata_word", ab.ram_wdata, ab.d_wdata);
         if (m_busy == 1) begin
            check("ram_addr_rmw", ab.ram_addr, m_rmw_addr);
            check("ram_wdata_rmw", ab.ram_wdata, ref_mem[widx(m_rmw_addr)]);
         end
         check("if_rvalid", ab.if_rvalid, exp_if_v[s]);
         check("d_rvalid", ab.d_rvalid, exp_d_v[s]);
         if (exp_if_v[s]) check("if_rdata", ab.if_rdata, exp_if_d[s]);
         if (exp_d_v[s])  check("d_rdata", ab.d_rdata, exp_d_d[s]);
         if (m_busy != 0) m_busy--;
         if (e_ig) begin
            m_last_d = 1'b0;
            exp_if_v[(cyc + LAT) % 8] = 1'b1;
            exp_if_d[(cyc + LAT) % 8] = ref_mem[widx(ab.if_addr)];
         end
         if (e_dg) begin
            m_last_d = 1'b1;
            wi = widx(ab.d_addr);
            if (!ab.d_we) begin
               exp_d_v[(cyc + LAT) % 8] = 1'b1;
               exp_d_d[(cyc + LAT) % 8] = ref_mem[wi];
            end else begin
               ref_mem[wi] = store_val(ref_mem[wi], ab.d_wdata, ab.d_size, ab.d_addr);
               if (RMW && !ab.d_size[1]) begin
                  m_busy     = LAT;
                  m_rmw_addr = ab.d_addr;
               end
            end
         end
      end
      exp_if_v[s] = 1'b0;
      exp_d_v[s]  = 1'b0;
      g_if = e_ig;
      g_d  = e_dg;
      cyc++;
      @(posedge clk);
      #1;
      if (g_if) ab.if_req = 1'b0;
      if (g_d)  ab.d_req  = 1'b0;
   endtask

   // driver tasks
   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic issue_if(input logic [31:0] a, output int waits);
      ab.if_req = 1'b1; ab.if_addr = a; waits = 0;
      for (int n = 0; n < 20; n++) begin
         cycle();
         if (g_if) break;
         waits++;
      end
      if (!g_if) begin
         check("if_gnt_timeout", g_if, 1);
         ab.if_req = 1'b0;
      end
   endtask

   task automatic issue_d(input logic we, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd);
      ab.d_req = 1'b1; ab.d_we = we; ab.d_size = sz; ab.d_addr = a; ab.d_wdata = wd;
      for (int n = 0; n < 20; n++) begin
         cycle();
         if (g_d) break;
      end
      if (!g_d) begin
         check("d_gnt_timeout", g_d, 1);
         ab.d_req = 1'b0;
      end
   endtask

   task automatic do_reset();
      ab.if_req = 1'b0; ab.d_req = 1'b0;
      rst_n = 1'b0;
      clear_model();
      idle(2);
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          w;
      logic [3:0]  gseq;
      logic [31:0] keep;
      rst_n = 1'b0; pre_we = 1'b0; pre_a = '0; pre_d = '0;
      ab.if_req = 1'b0; ab.if_addr = '0;
      ab.d_req = 1'b0; ab.d_we = 1'b0; ab.d_size = 2'b10; ab.d_addr = '0; ab.d_wdata = '0;
      if_cap = '0; d_cap = '0;
      for (int i = 0; i < 512; i++) ref_mem[i] = '0;
      clear_model();
      // preload first 128 words while held in reset
      for (int i = 0; i < 128; i++) begin
         @(posedge clk); #1;
         pre_we = 1'b1; pre_a = 9'(i); pre_d = $urandom() | 32'h1;
         ref_mem[i] = pre_d;
      end
      @(posedge clk); #1;
      pre_we = 1'b0;
      do_reset();

      // fetch-only after reset: grant at once, data two cycles later
      issue_if(32'h10, w);
      check("fetch_wait", w, 0);
      idle(2);
      check("fetch_data_ram4", if_cap, ref_mem[4]);

      // both ports held from reset: IF, D, IF, D
      do_reset();
      for (int i = 0; i < 4; i++) begin
         if (!ab.if_req) begin ab.if_req = 1'b1; ab.if_addr = 32'h100 + 32'(4 * i); end
         if (!ab.d_req) begin
            ab.d_req = 1'b1; ab.d_we = 1'b0; ab.d_size = 2'b10; ab.d_addr = 32'h180 + 32'(4 * i);
         end
         cycle();
         gseq[i] = obs_d_gnt;
      end
      ab.if_req = 1'b0; ab.d_req = 1'b0;
      idle(3);
      check("arb_order", 32'(gseq), 32'b1010);

      // word store then load
      issue_d(1'b1, 2'b10, 32'h20, 32'hDEADBEEF);
      issue_d(1'b0, 2'b10, 32'h20, 32'h0);
      idle(2);
      check("word_store_load", d_cap, 32'hDEADBEEF);

      // byte then half store into a known word
      issue_d(1'b1, 2'b10, 32'h40, 32'h11223344);
      issue_d(1'b1, 2'b00, 32'h41, 32'h000000AA);
      issue_d(1'b0, 2'b10, 32'h40, 32'h0);
      idle(2);
      check("byte_store_load", d_cap, EXP_BYTE);
      issue_d(1'b1, 2'b01, 32'h42, 32'h0000BEEF);
      issue_d(1'b0, 2'b10, 32'h40, 32'h0);
      idle(2);
      check("half_store_load", d_cap, EXP_HALF);

      // fetch in flight, then sub-word store, then fetch blocked by it
      issue_if(32'h80, w);
      issue_d(1'b1, 2'b00, 32'h81, 32'h0000005C);
      issue_if(32'h84, w);
      check("fetch_wait_rmw", 32'(w), EXP_WAIT);
      idle(3);

      // reset pulse while a sub-word store is waiting for its read
      issue_d(1'b1, 2'b10, 32'h60, 32'h5A5A5A5A);
      idle(2);
      issue_d(1'b1, 2'b00, 32'h60, 32'h00000077);
      keep = EXP_RST;
      rst_n = 1'b0;
      clear_model();
      idle(3);
      rst_n = 1'b1;
      ref_mem[widx(32'h60)] = keep;
      idle(1);
      issue_d(1'b0, 2'b10, 32'h60, 32'h0);
      idle(2);
      check("rst_mid_rmw_word", d_cap, EXP_RST);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         if (!ab.if_req && $urandom_range(0, 2) == 0) begin
            ab.if_req = 1'b1; ab.if_addr = 32'($urandom_range(0, 31)) << 2;
         end
         if (!ab.d_req && $urandom_range(0, 2) == 0) begin
            ab.d_req   = 1'b1;
            ab.d_we    = 1'($urandom_range(0, 1));
            ab.d_size  = 2'($urandom_range(0, 3));
            ab.d_addr  = 32'($urandom_range(0, 127));
            ab.d_wdata = $urandom();
         end
         cycle();
      end
      ab.if_req = 1'b0; ab.d_req = 1'b0;
      idle(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
